// File: rtl/utils_top.sv
// Shared execute-stage definitions: branch funct3 codes, BHT counter type and
// branch-resolve FSM states.
package utils_top;

  localparam logic [2:0] ALU_BEQ  = 3'b000;
  localparam logic [2:0] ALU_BLT  = 3'b100;
  localparam logic [2:0] ALU_BGE  = 3'b101;
  localparam logic [2:0] ALU_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_CTR_RST = 2'b01;

  typedef enum logic {BR_IDLE, BR_KILL} br_state_t;

endpackage

// File: rtl/execute_bht.sv
// Bimodal branch history table: 2-bit saturating counters with a synchronous-reset
// update port and a combinational read port (read sees the pre-write value).
module execute_bht
  import utils_top::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken
);

  bht_ctr_t bht_q [BHT_DEPTH];
  bht_ctr_t upd_cur;
  bht_ctr_t upd_nxt;

  always_comb begin
    upd_cur = bht_q[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken && (upd_cur != 2'b11)) begin
      upd_nxt = upd_cur + 2'b01;
    end else if (!upd_taken && (upd_cur != 2'b00)) begin
      upd_nxt = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= BHT_CTR_RST;
      end
    end else if (upd_en) begin
      bht_q[upd_idx] <= upd_nxt;
    end
  end

  assign rd_taken = bht_q[rd_idx][1];

endmodule

// File: rtl/execute_branch_resolve.sv
// Execute-stage branch resolution: condition decode, flush/kill FSM, BHT owner.
// Optional performance counters enabled by defining BR_PERF_CNT_EN.
module execute_branch_resolve
  import utils_top::*;
#(
  parameter int unsigned DAT_W     = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned KILL_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic             inst_branch,
  input  logic             inst_jalr,
  input  logic [2:0]       funct3,
  input  logic [DAT_W-1:0] alu_dat_out,
  input  logic [DAT_W-1:0] ex_pc,
  input  logic             br_pred,
  input  logic [DAT_W-1:0] fetch_pc,
  output logic             fetch_pred,
  output logic             flush,
  output logic             kill,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned KW    = (KILL_CYC > 1) ? $clog2(KILL_CYC) : 1;

  br_state_t         state_q, state_d;
  logic [KW-1:0]     kcnt_q, kcnt_d;
  logic              flush_q;
  logic              br_act;
  logic              accept;
  logic              flush_req;
  logic              br_upd;

  // Only the index bits of the PCs matter here.
  logic unused_pc;
  assign unused_pc = ^{ex_pc[DAT_W-1:IDX_W+2], ex_pc[1:0],
                       fetch_pc[DAT_W-1:IDX_W+2], fetch_pc[1:0]};

  always_comb begin
    unique case (funct3)
      ALU_BGE, ALU_BGEU: br_act = ~alu_dat_out[0];
      ALU_BLT:           br_act = alu_dat_out[0];
      ALU_BEQ:           br_act = ~|alu_dat_out;
      default:           br_act = |alu_dat_out;
    endcase
  end

  assign accept    = vld_in && (state_q == BR_IDLE);
  assign flush_req = accept && (inst_jalr || (inst_branch && (br_pred ^ br_act)));
  // JALR takes priority over a simultaneously flagged branch.
  assign br_upd    = accept && inst_branch && !inst_jalr;

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    unique case (state_q)
      BR_IDLE: begin
        if (flush_req) begin
          state_d = BR_KILL;
          kcnt_d  = KW'(KILL_CYC - 1);
        end
      end
      BR_KILL: begin
        if (kcnt_q == '0) begin
          state_d = BR_IDLE;
        end else begin
          kcnt_d = kcnt_q - KW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BR_IDLE;
      kcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      flush_q <= flush_req;
    end
  end

  assign flush = flush_q;
  assign kill  = (state_q == BR_KILL);

  execute_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (br_upd),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (br_act),
    .rd_idx    (fetch_pc[IDX_W+1:2]),
    .rd_taken  (fetch_pred)
  );

`ifdef BR_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (br_upd) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (br_pred ^ br_act) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign br_cnt      = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_execute_branch_resolve.sv
// Scoreboard bench for execute_branch_resolve: directed plan scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_execute_branch_resolve;

  localparam int DAT_W     = 32;
  localparam int BHT_DEPTH = 64;
  localparam int KILL_CYC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_in = 1'b0;
  logic        inst_branch = 1'b0;
  logic        inst_jalr = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_dat_out = '0;
  logic [31:0] ex_pc = '0;
  logic        br_pred = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_pred;
  logic        flush;
  logic        kill;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  execute_branch_resolve #(
    .DAT_W     (DAT_W),
    .BHT_DEPTH (BHT_DEPTH),
    .KILL_CYC  (KILL_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_in      (vld_in),
    .inst_branch (inst_branch),
    .inst_jalr   (inst_jalr),
    .funct3      (funct3),
    .alu_dat_out (alu_dat_out),
    .ex_pc       (ex_pc),
    .br_pred     (br_pred),
    .fetch_pc    (fetch_pc),
    .fetch_pred  (fetch_pred),
    .flush       (flush),
    .kill        (kill),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        chk;
    bit        flush;
    bit        kill;
    bit        pred;
    bit [31:0] br;
    bit [31:0] mis;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int        m_bht [BHT_DEPTH];
  int        m_kill_left = 0;
  bit        m_flush = 0;
  bit [31:0] m_br = 0;
  bit [31:0] m_mis = 0;
  bit        m_known = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic bit taken(bit [2:0] f3, bit [31:0] alu);
    case (f3)
      3'd5, 3'd7: return !alu[0];
      3'd4:       return alu[0];
      3'd0:       return alu == 0;
      default:    return alu != 0;
    endcase
  endfunction

  task automatic drive(input bit r, input bit v, input bit b, input bit j, input bit [2:0] f3,
                       input bit [31:0] alu, input bit [31:0] pc, input bit pred,
                       input bit [31:0] fpc);
    exp_t e;
    bit   acc;
    bit   act;
    bit   freq;
    int   ix;
    @(negedge clk);
    rst = r; vld_in = v; inst_branch = b; inst_jalr = j; funct3 = f3;
    alu_dat_out = alu; ex_pc = pc; br_pred = pred; fetch_pc = fpc;
    e.chk   = m_known;
    e.flush = m_flush;
    e.kill  = (m_kill_left > 0);
    e.pred  = (m_bht[(fpc >> 2) % BHT_DEPTH] >= 2);
`ifdef BR_PERF_CNT_EN
    e.br  = m_br;
    e.mis = m_mis;
`else
    e.br  = 0;
    e.mis = 0;
`endif
    sb.push_back(e);
    if (r) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_kill_left = 0;
      m_flush = 0;
      m_br = 0;
      m_mis = 0;
      m_known = 1;
    end else begin
      acc  = v && (m_kill_left == 0);
      act  = taken(f3, alu);
      freq = acc && (j || (b && (pred != act)));
      if (m_kill_left > 0) m_kill_left--;
      m_flush = freq;
      if (freq) m_kill_left = KILL_CYC;
      if (acc && b && !j) begin
        ix = (pc >> 2) % BHT_DEPTH;
        if (act) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
        else     m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
        m_br++;
        if (pred != act) m_mis++;
      end
    end
  endtask

  task automatic idle(input bit [31:0] fpc);
    drive(0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 0, fpc);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare just before the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check("flush", {31'd0, flush}, {31'd0, e.flush});
          check("kill", {31'd0, kill}, {31'd0, e.kill});
          check("fetch_pred", {31'd0, fetch_pred}, {31'd0, e.pred});
          check("br_cnt", br_cnt, e.br);
          check("mispred_cnt", mispred_cnt, e.mis);
        end
      end
    end
  end

  initial begin
    bit [31:0] alu;
    bit [31:0] pc;
    bit [31:0] fpc;
    foreach (m_bht[i]) m_bht[i] = 1;

    drive(1, 0, 0, 0, 3'd0, 0, 0, 0, 32'h100);
    drive(1, 0, 0, 0, 3'd0, 0, 0, 0, 32'h100);
    idle(32'h100);

    // Correct prediction: BEQ taken, predicted taken
    drive(0, 1, 1, 0, 3'd0, 32'd0, 32'h100, 1, 32'h100);
    idle(32'h100);
    idle(32'h100);

    // Mispredict, then mispredicting branches inside the kill window
    drive(0, 1, 1, 0, 3'd4, 32'd1, 32'h200, 0, 32'h200);
    drive(0, 1, 1, 0, 3'd4, 32'd1, 32'h200, 0, 32'h200);
    drive(0, 1, 1, 0, 3'd4, 32'd1, 32'h200, 0, 32'h200);
    idle(32'h200);
    idle(32'h200);

    // Saturation at PC 0
    repeat (4) drive(0, 1, 1, 0, 3'd1, 32'd7, 32'h0, 1, 32'h0);
    idle(32'h0);
    repeat (5) drive(0, 1, 1, 0, 3'd1, 32'd0, 32'h0, 0, 32'h0);
    idle(32'h0);

    // JALR with branch flag: flush, no BHT update, no count
    drive(0, 1, 1, 1, 3'd1, 32'd5, 32'h100, 1, 32'h100);
    repeat (3) idle(32'h100);

    // Read/write on the same index in one cycle
    drive(0, 1, 1, 0, 3'd1, 32'd5, 32'h8, 1, 32'h8);
    idle(32'h8);

    // Reset during the kill window
    drive(0, 1, 1, 0, 3'd0, 32'd0, 32'h8, 0, 32'h8);
    idle(32'h8);
    drive(1, 0, 0, 0, 3'd0, 0, 0, 0, 32'h8);
    idle(32'h8);
    idle(32'h100);

    // Random traffic over a small PC set to force aliasing
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 2))
        0:       alu = 32'd0;
        1:       alu = 32'd1;
        default: alu = $urandom;
      endcase
      pc  = $urandom_range(0, 15) << 2;
      fpc = ($urandom_range(0, 3) == 0) ? pc : ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 199) == 0) pc = pc | 32'h1000;
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            3'($urandom_range(0, 7)), alu, pc, 1'($urandom_range(0, 1)), fpc);
    end

    repeat (3) idle(32'h0);
    @(negedge clk);
    #4;
    if (sb.size() > 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected at most 1", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
